// File: rtl/crtc_pkg.sv
// rtl/crtc_pkg.sv - shared widths, timing-set type and 640x480@60 default timings
package crtc_pkg;

  localparam int CW_DEF = 12;
  localparam int FW_DEF = 8;

  typedef struct packed {
    logic [CW_DEF-1:0] total;
    logic [CW_DEF-1:0] sstart;
    logic [CW_DEF-1:0] send;
    logic [CW_DEF-1:0] vstart;
    logic [CW_DEF-1:0] vend;
  } timing_t;

  // Video start is the count before the first visible pixel/line, since the den flops lag by one step.
  localparam timing_t VGA_H = '{total: 12'd799, sstart: 12'd656, send: 12'd752,
                                vstart: 12'd799, vend: 12'd639};
  localparam timing_t VGA_V = '{total: 12'd524, sstart: 12'd490, send: 12'd492,
                                vstart: 12'd524, vend: 12'd479};
  localparam logic VGA_HPOL = 1'b0;
  localparam logic VGA_VPOL = 1'b0;

endpackage

// File: rtl/crtc_axis.sv
// rtl/crtc_axis.sv - one raster axis: counter, shadowed timings, sync decode and display-enable flop
module crtc_axis
  import crtc_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          adv_i,
  input  logic          load_i,
  input  logic [CW-1:0] total_i,
  input  logic [CW-1:0] sstart_i,
  input  logic [CW-1:0] send_i,
  input  logic [CW-1:0] vstart_i,
  input  logic [CW-1:0] vend_i,
  input  logic          pol_i,
  output logic [CW-1:0] cnt_o,
  output logic          at_total_o,
  output logic          wrap_o,
  output logic          sync_o,
  output logic          den_o
);

  typedef struct packed {
    logic [CW-1:0] total;
    logic [CW-1:0] sstart;
    logic [CW-1:0] send;
    logic [CW-1:0] vstart;
    logic [CW-1:0] vend;
    logic          pol;
  } shadow_t;

  shadow_t       shadow_in, shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          den_q, den_d;
  logic          in_sync;

  assign shadow_in  = {total_i, sstart_i, send_i, vstart_i, vend_i, pol_i};
  assign at_total_o = (cnt_q == shadow_q.total);
  assign wrap_o     = adv_i && (at_total_o || (cnt_q == {CW{1'b1}}));

  always_comb begin
    shadow_d = load_i ? shadow_in : shadow_q;
    cnt_d    = cnt_q;
    den_d    = den_q;
    if (adv_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
      // End match wins so equal start/end keeps the enable low.
      if (cnt_q == shadow_q.vend) begin
        den_d = 1'b0;
      end else if (cnt_q == shadow_q.vstart) begin
        den_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_q <= shadow_in;
      cnt_q    <= '0;
      den_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      den_q    <= den_d;
    end
  end

  assign in_sync = (cnt_q >= shadow_q.sstart) && (cnt_q < shadow_q.send);
  assign sync_o  = in_sync ? shadow_q.pol : ~shadow_q.pol;
  assign cnt_o   = cnt_q;
  assign den_o   = den_q;

endmodule

// File: rtl/crtc_ng.sv
// rtl/crtc_ng.sv - raster timing generator; define CRTC_RASTER_IRQ_EN to add the raster-line interrupt
module crtc_ng
  import crtc_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic          dotclk_i,
  input  logic          reset_i,
  input  logic [CW-1:0] htotal_i,
  input  logic [CW-1:0] hsstart_i,
  input  logic [CW-1:0] hsend_i,
  input  logic [CW-1:0] hvstart_i,
  input  logic [CW-1:0] hvend_i,
  input  logic [CW-1:0] vtotal_i,
  input  logic [CW-1:0] vsstart_i,
  input  logic [CW-1:0] vsend_i,
  input  logic [CW-1:0] vvstart_i,
  input  logic [CW-1:0] vvend_i,
  input  logic          hspol_i,
  input  logic          vspol_i,
  input  logic [CW-1:0] irqline_i,
  input  logic          irq_ack_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          hden_o,
  output logic          vden_o,
  output logic          de_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          sol_o,
  output logic          sof_o,
  output logic [FW-1:0] frame_o,
  output logic          irq_o
);

  logic          h_at_total, h_wrap, v_at_total, v_wrap_unused;
  logic          frame_end;
  logic [FW-1:0] frame_q, frame_d;

  assign frame_end = h_at_total && v_at_total;

  crtc_axis #(.CW(CW)) u_haxis (
    .clk_i(dotclk_i), .reset_i(reset_i), .adv_i(1'b1), .load_i(frame_end),
    .total_i(htotal_i), .sstart_i(hsstart_i), .send_i(hsend_i),
    .vstart_i(hvstart_i), .vend_i(hvend_i), .pol_i(hspol_i),
    .cnt_o(x_o), .at_total_o(h_at_total), .wrap_o(h_wrap),
    .sync_o(hsync_o), .den_o(hden_o)
  );

  // The vertical axis only steps on line wrap, which also times vden updates.
  crtc_axis #(.CW(CW)) u_vaxis (
    .clk_i(dotclk_i), .reset_i(reset_i), .adv_i(h_wrap), .load_i(frame_end),
    .total_i(vtotal_i), .sstart_i(vsstart_i), .send_i(vsend_i),
    .vstart_i(vvstart_i), .vend_i(vvend_i), .pol_i(vspol_i),
    .cnt_o(y_o), .at_total_o(v_at_total), .wrap_o(v_wrap_unused),
    .sync_o(vsync_o), .den_o(vden_o)
  );

  always_comb begin
    frame_d = frame_end ? frame_q + 1'b1 : frame_q;
  end

  always_ff @(posedge dotclk_i) begin
    if (reset_i) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign frame_o = frame_q;
  assign de_o    = hden_o & vden_o;
  assign sol_o   = (x_o == '0);
  assign sof_o   = sol_o && (y_o == '0);

`ifdef CRTC_RASTER_IRQ_EN
  logic [CW-1:0] irqline_q, irqline_d;
  logic          irq_q, irq_d;

  always_comb begin
    irqline_d = frame_end ? irqline_i : irqline_q;
    irq_d     = irq_q;
    if (h_at_total && (y_o == irqline_q)) begin
      irq_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge dotclk_i) begin
    if (reset_i) begin
      irqline_q <= irqline_i;
      irq_q     <= 1'b0;
    end else begin
      irqline_q <= irqline_d;
      irq_q     <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^{irqline_i, irq_ack_i};
  assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_crtc_ng.sv
// tb/tb_crtc_ng.sv - randomized scoreboard bench for crtc_ng against a behavioural raster model
module tb_crtc_ng;

  localparam int CW   = 12;
  localparam int FW   = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic          dotclk_i = 1'b0;
  logic          reset_i, hspol_i, vspol_i, irq_ack_i;
  logic [CW-1:0] htotal_i, hsstart_i, hsend_i, hvstart_i, hvend_i;
  logic [CW-1:0] vtotal_i, vsstart_i, vsend_i, vvstart_i, vvend_i, irqline_i;
  logic          hsync_o, vsync_o, hden_o, vden_o, de_o, sol_o, sof_o, irq_o;
  logic [CW-1:0] x_o, y_o;
  logic [FW-1:0] frame_o;

  crtc_ng #(.CW(CW), .FW(FW)) dut (
    .dotclk_i(dotclk_i), .reset_i(reset_i),
    .htotal_i(htotal_i), .hsstart_i(hsstart_i), .hsend_i(hsend_i),
    .hvstart_i(hvstart_i), .hvend_i(hvend_i),
    .vtotal_i(vtotal_i), .vsstart_i(vsstart_i), .vsend_i(vsend_i),
    .vvstart_i(vvstart_i), .vvend_i(vvend_i),
    .hspol_i(hspol_i), .vspol_i(vspol_i),
    .irqline_i(irqline_i), .irq_ack_i(irq_ack_i),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .hden_o(hden_o), .vden_o(vden_o),
    .de_o(de_o), .x_o(x_o), .y_o(y_o), .sol_o(sol_o), .sof_o(sof_o),
    .frame_o(frame_o), .irq_o(irq_o)
  );

  always #5 dotclk_i = ~dotclk_i;

  typedef struct {
    int ht, hss, hse, hvs, hve;
    int vt, vss, vse, vvs, vve;
    int irql;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    int   x, y, frame;
    bit   hden, vden, irq;
    cfg_t sh;
  } mstate_t;

  typedef struct {
    int due, x, y, frame;
    bit hs, vs, hden, vden, de, sol, sof, irq;
  } exp_t;

  cfg_t    cur;
  mstate_t m;
  exp_t    sb[$];
  int      cyc = 0;
  int      vectors = 0;
  int      miscompares = 0;

  always @(posedge dotclk_i) cyc <= cyc + 1;

  // One raster clock of the reference: the state after the edge, from the state and inputs before it.
  function automatic mstate_t next_state(mstate_t s, cfg_t c, logic rst, logic ack);
    mstate_t n;
    bit      at_htotal, line_end, frame_end;
    n = s;
    if (rst) begin
      n.x = 0; n.y = 0; n.frame = 0;
      n.hden = 0; n.vden = 0; n.irq = 0;
      n.sh = c;
      return n;
    end
    at_htotal = (s.x == s.sh.ht);
    line_end  = at_htotal || (s.x == MAXV);
    frame_end = at_htotal && (s.y == s.sh.vt);
    if (s.x == s.sh.hve) n.hden = 0;
    else if (s.x == s.sh.hvs) n.hden = 1;
    if (at_htotal) begin
      if (s.y == s.sh.vve) n.vden = 0;
      else if (s.y == s.sh.vvs) n.vden = 1;
    end
    if (at_htotal && s.y == s.sh.irql) n.irq = 1;
    else if (ack) n.irq = 0;
    n.x = line_end ? 0 : s.x + 1;
    if (line_end) n.y = (s.y == s.sh.vt || s.y == MAXV) ? 0 : s.y + 1;
    if (frame_end) begin
      n.frame = (s.frame + 1) % (1 << FW);
      n.sh    = c;
    end
    return n;
  endfunction

  function automatic exp_t expect_of(mstate_t s);
    exp_t e;
    e.due   = 0;
    e.x     = s.x;
    e.y     = s.y;
    e.frame = s.frame;
    e.hs    = (s.x >= s.sh.hss && s.x < s.sh.hse) ? s.sh.hp : !s.sh.hp;
    e.vs    = (s.y >= s.sh.vss && s.y < s.sh.vse) ? s.sh.vp : !s.sh.vp;
    e.hden  = s.hden;
    e.vden  = s.vden;
    e.de    = s.hden && s.vden;
    e.sol   = (s.x == 0);
    e.sof   = (s.x == 0) && (s.y == 0);
`ifdef CRTC_RASTER_IRQ_EN
    e.irq   = s.irq;
`else
    e.irq   = 1'b0;
`endif
    return e;
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.ht = $urandom_range(15, 0);  c.hss = $urandom_range(15, 0); c.hse = $urandom_range(15, 0);
    c.hvs = $urandom_range(15, 0); c.hve = $urandom_range(15, 0);
    c.vt = $urandom_range(15, 0);  c.vss = $urandom_range(15, 0); c.vse = $urandom_range(15, 0);
    c.vvs = $urandom_range(15, 0); c.vve = $urandom_range(15, 0);
    c.irql = $urandom_range(15, 0);
    c.hp = ($urandom_range(1, 0) == 1);
    c.vp = ($urandom_range(1, 0) == 1);
    return c;
  endfunction

  task automatic drive();
    htotal_i  = CW'(cur.ht);  hsstart_i = CW'(cur.hss); hsend_i = CW'(cur.hse);
    hvstart_i = CW'(cur.hvs); hvend_i   = CW'(cur.hve);
    vtotal_i  = CW'(cur.vt);  vsstart_i = CW'(cur.vss); vsend_i = CW'(cur.vse);
    vvstart_i = CW'(cur.vvs); vvend_i   = CW'(cur.vve);
    irqline_i = CW'(cur.irql);
    hspol_i   = cur.hp;
    vspol_i   = cur.vp;
  endtask

  task automatic step();
    exp_t e;
    drive();
    m     = next_state(m, cur, reset_i, irq_ack_i);
    e     = expect_of(m);
    e.due = cyc + 1;
    sb.push_back(e);
    @(posedge dotclk_i);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req, inout bit bad);
    if (act !== req) begin
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
      bad = 1'b1;
    end
  endtask

  always @(negedge dotclk_i) begin
    exp_t e;
    bit   bad;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      bad = 1'b0;
      vectors++;
      cmp("x_o",     32'(x_o),     32'(e.x),     bad);
      cmp("y_o",     32'(y_o),     32'(e.y),     bad);
      cmp("frame_o", 32'(frame_o), 32'(e.frame), bad);
      cmp("hsync_o", 32'(hsync_o), 32'(e.hs),    bad);
      cmp("vsync_o", 32'(vsync_o), 32'(e.vs),    bad);
      cmp("hden_o",  32'(hden_o),  32'(e.hden),  bad);
      cmp("vden_o",  32'(vden_o),  32'(e.vden),  bad);
      cmp("de_o",    32'(de_o),    32'(e.de),    bad);
      cmp("sol_o",   32'(sol_o),   32'(e.sol),   bad);
      cmp("sof_o",   32'(sof_o),   32'(e.sof),   bad);
      cmp("irq_o",   32'(irq_o),   32'(e.irq),   bad);
      if (bad) miscompares++;
    end
  end

  initial begin
    int n;
    irq_ack_i = 1'b0;
    reset_i   = 1'b1;
    cur = '{ht: 9, hss: 8, hse: 9, hvs: 2, hve: 7, vt: 5, vss: 1, vse: 2,
            vvs: 5, vve: 3, irql: 3, hp: 1'b0, vp: 1'b1};
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 150; i++) begin
      irq_ack_i = ($urandom_range(7, 0) == 0);
      step();
    end
    irq_ack_i = 1'b1;
    for (int i = 0; i < 40; i++) step();
    irq_ack_i = 1'b0;

    // Shorter lines programmed mid-frame only take hold after the frame end.
    cur.ht = 5;
    for (int i = 0; i < 200; i++) step();

    n = 0;
    while (!(m.x == 4 && m.y == 2 && m.hden) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) begin
      $display("FAIL reset_point: got no x=4,y=2,hden=1 within %0d cycles, expected one", n);
      miscompares++;
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 30; i++) step();

    cur.hvs = 4;
    cur.hve = 4;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 100; i++) step();

    for (int r = 0; r < 20; r++) begin
      cur     = rand_cfg();
      reset_i = ($urandom_range(1, 0) == 1);
      step();
      for (int i = 0; i < 150; i++) begin
        irq_ack_i = ($urandom_range(3, 0) == 0);
        reset_i   = ($urandom_range(199, 0) == 0);
        if ($urandom_range(29, 0) == 0) cur = rand_cfg();
        step();
      end
      reset_i   = 1'b0;
      irq_ack_i = 1'b0;
    end

    // Full-range vertical total: y must run to all-ones and wrap.
    cur = '{ht: 1, hss: 0, hse: 1, hvs: 0, hve: 1, vt: MAXV, vss: 2, vse: 4,
            vvs: 1, vve: 3, irql: MAXV, hp: 1'b1, vp: 1'b0};
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 2 * (MAXV + 1) + 10; i++) begin
      irq_ack_i = ($urandom_range(15, 0) == 0);
      step();
    end
    irq_ack_i = 1'b0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge dotclk_i);
    #1;
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
